// File: rtl/alu_pkg.sv
// Shared ALU definitions: function codes, default operand width and the
// sequencer state encoding used by the multi-cycle units.
package alu_pkg;

    localparam int DATA_WIDTH = 32;

    localparam logic [5:0] MUL  = 6'b011001;
    localparam logic [5:0] DIVU = 6'b011011;
    localparam logic [5:0] OUT  = 6'b111111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/divider_if.sv
// ALU-side bundle shared with the multiplier: operands, function code,
// the 64-bit HI/LO result and the completion status flags.
interface divider_if #(
    parameter int WIDTH = alu_pkg::DATA_WIDTH
);
    logic [WIDTH-1:0]   dataA;
    logic [WIDTH-1:0]   dataB;
    logic [5:0]         Signal;
    logic [2*WIDTH-1:0] dataOut;
    logic               busy;
    logic               done;
    logic               div_zero;

    modport master (
        output dataA, dataB, Signal,
        input  dataOut, busy, done, div_zero
    );

    modport slave (
        input  dataA, dataB, Signal,
        output dataOut, busy, done, div_zero
    );

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift {R,Q} left, trial-subtract the
// divisor, keep the difference and set the quotient bit when it fits.
module div_step #(
    parameter int WIDTH = alu_pkg::DATA_WIDTH
) (
    input  logic [WIDTH:0]   r,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH:0]   rNext,
    output logic [WIDTH-1:0] qNext
);

    logic [WIDTH+1:0] rShifted;
    logic [WIDTH+1:0] trial;

    // One guard bit above R makes the trial's sign bit the borrow-out.
    always_comb begin
        rShifted = {r, q[WIDTH-1]};
        trial    = rShifted - {2'b00, d};
        if (!trial[WIDTH+1]) begin
            rNext = trial[WIDTH:0];
            qNext = {q[WIDTH-2:0], 1'b1};
        end else begin
            rNext = rShifted[WIDTH:0];
            qNext = {q[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock,
// result {remainder, quotient} registered for the HI/LO path.
module divider #(
    parameter int         WIDTH = alu_pkg::DATA_WIDTH,
    parameter logic [5:0] DIVU  = alu_pkg::DIVU,
    parameter int         CNT_W = 6
) (
    input logic      clk,
    input logic      reset,
    divider_if.slave bus
);
    import alu_pkg::*;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] FIN_END   = CNT_W'(WIDTH);

    state_t           state;
    state_t           nextState;
    logic [WIDTH:0]   rReg;
    logic [WIDTH-1:0] qReg;
    logic [WIDTH-1:0] dReg;
    logic [CNT_W-1:0] cnt;
    logic             zeroFlag;
    logic [WIDTH:0]   rStep;
    logic [WIDTH-1:0] qStep;
    logic             start;
    logic             zeroDivisor;

    assign start       = (state == IDLE) && (bus.Signal == DIVU);
    assign zeroDivisor = (bus.dataB == '0);

    div_step #(.WIDTH(WIDTH)) step (
        .r     (rReg),
        .q     (qReg),
        .d     (dReg),
        .rNext (rStep),
        .qNext (qStep)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nextState;
    end

    // FIN lasts until the counter reaches WIDTH, which is one cycle after the
    // last iteration and two cycles for the divide-by-zero shortcut.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (start) nextState = zeroDivisor ? FIN : RUN;
            RUN:  if (cnt == LAST_STEP) nextState = FIN;
            FIN:  if (cnt == FIN_END) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rReg         <= '0;
            qReg         <= '0;
            dReg         <= '0;
            cnt          <= '0;
            zeroFlag     <= 1'b0;
            bus.dataOut  <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.div_zero <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dReg         <= bus.dataB;
                        qReg         <= bus.dataA;
                        rReg         <= '0;
                        cnt          <= zeroDivisor ? LAST_STEP : '0;
                        zeroFlag     <= zeroDivisor;
                        bus.busy     <= 1'b1;
                        bus.div_zero <= 1'b0;
                    end
                end
                RUN: begin
                    rReg <= rStep;
                    qReg <= qStep;
                    cnt  <= cnt + 1'b1;
                end
                FIN: begin
                    if (cnt == FIN_END) begin
                        bus.dataOut  <= zeroFlag ? {qReg, {WIDTH{1'b1}}}
                                                 : {rReg[WIDTH-1:0], qReg};
                        bus.done     <= 1'b1;
                        bus.busy     <= 1'b0;
                        bus.div_zero <= zeroFlag;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divider.sv
// Directed and random bench for the divider, checked against plain
// integer division plus a standalone check of one div_step iteration.
module tb_divider;
    import alu_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic [63:0] lastOut;

    logic [32:0] stR;
    logic [31:0] stQ;
    logic [31:0] stD;
    logic [32:0] stRN;
    logic [31:0] stQN;

    divider_if #(.WIDTH(32)) bus ();

    divider #(.WIDTH(32), .DIVU(DIVU), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    div_step #(.WIDTH(32)) stepUnit (
        .r     (stR),
        .q     (stQ),
        .d     (stD),
        .rNext (stRN),
        .qNext (stQN)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] refDiv(input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
    endfunction

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.dataA  = a;
        bus.dataB  = b;
        bus.Signal = DIVU;
        @(posedge clk);
        #1;
        bus.Signal = 6'd0;
        bus.dataA  = $urandom;
        bus.dataB  = $urandom;
    endtask

    // Counts edges after the start edge until done, checking that the result
    // holds and busy stays high meanwhile; disturb pokes DIVU while busy.
    task automatic waitDone(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input bit disturb);
        logic [63:0] expOut;
        int          expLat;
        int          k;
        bit          seen;
        expOut = refDiv(a, b);
        expLat = (b == 32'd0) ? 2 : 33;
        k      = 0;
        seen   = 1'b0;
        while (!seen && k <= 80) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
            end else begin
                checkOutput({tag, " hold"}, bus.dataOut, lastOut);
                checkOutput({tag, " busy"}, 64'(bus.busy), 64'd1);
                if (disturb) begin
                    if ((k >= 5 && k < 9) || k == 32) begin
                        bus.Signal = DIVU;
                        bus.dataA  = 32'd9;
                        bus.dataB  = 32'd2;
                    end else begin
                        bus.Signal = 6'd0;
                        bus.dataA  = $urandom;
                        bus.dataB  = $urandom;
                    end
                end
                @(posedge clk);
                k++;
            end
        end
        bus.Signal = 6'd0;
        checkOutput({tag, " done seen"}, 64'(seen), 64'd1);
        if (seen) begin
            checkOutput({tag, " latency"}, 64'(k), 64'(expLat));
            checkOutput({tag, " dataOut"}, bus.dataOut, expOut);
            checkOutput({tag, " div_zero"}, 64'(bus.div_zero), 64'(b == 32'd0));
            checkOutput({tag, " busy at done"}, 64'(bus.busy), 64'd0);
        end
        lastOut = expOut;
        @(posedge clk);
        @(negedge clk);
        checkOutput({tag, " done width"}, 64'(bus.done), 64'd0);
        checkOutput({tag, " result kept"}, bus.dataOut, expOut);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [32:0] rs;
        int          pulses;
        checks     = 0;
        errors     = 0;
        lastOut    = 64'd0;
        reset      = 1'b0;
        bus.Signal = 6'd0;
        bus.dataA  = 32'd0;
        bus.dataB  = 32'd0;
        stR = '0; stQ = '0; stD = 32'd1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset dataOut", bus.dataOut, 64'd0);
        checkOutput("reset busy", 64'(bus.busy), 64'd0);
        checkOutput("reset done", 64'(bus.done), 64'd0);
        checkOutput("reset div_zero", 64'(bus.div_zero), 64'd0);
        reset = 1'b1;

        $display("[TB] single iteration checks");
        for (int i = 0; i < 20; i++) begin
            stD = $urandom >> $urandom_range(0, 31);
            if (stD == 32'd0) stD = 32'd1;
            stR = 33'($urandom % stD);
            stQ = $urandom;
            #1;
            rs = {stR[31:0], stQ[31]};
            if (rs >= {1'b0, stD})
                checkOutput("step", {31'd0, stRN, stQN}, {31'd0, rs - {1'b0, stD}, stQ[30:0], 1'b1});
            else
                checkOutput("step", {31'd0, stRN, stQN}, {31'd0, rs, stQ[30:0], 1'b0});
        end

        $display("[TB] basic 100/7");
        applyStimulus(32'd100, 32'd7);
        waitDone("basic", 32'd100, 32'd7, 1'b0);

        $display("[TB] reset mid-operation");
        applyStimulus(32'd1000, 32'd7);
        repeat (10) @(negedge clk);
        checkOutput("pre-abort busy", 64'(bus.busy), 64'd1);
        reset = 1'b0;
        #1;
        checkOutput("abort dataOut", bus.dataOut, 64'd0);
        checkOutput("abort busy", 64'(bus.busy), 64'd0);
        checkOutput("abort done", 64'(bus.done), 64'd0);
        lastOut = 64'd0;
        repeat (2) @(negedge clk);
        reset  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) pulses++;
        end
        checkOutput("abort no done", 64'(pulses), 64'd0);
        applyStimulus(32'd1000, 32'd7);
        waitDone("after abort", 32'd1000, 32'd7, 1'b0);

        $display("[TB] edge values");
        applyStimulus(32'hFFFF_FFFF, 32'd1);
        waitDone("max/1", 32'hFFFF_FFFF, 32'd1, 1'b0);
        applyStimulus(32'd5, 32'd9);
        waitDone("5/9", 32'd5, 32'd9, 1'b0);
        applyStimulus(32'h8000_0000, 32'hFFFF_FFFF);
        waitDone("msb/max", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

        $display("[TB] divide by zero");
        applyStimulus(32'd123, 32'd0);
        waitDone("div0", 32'd123, 32'd0, 1'b0);
        checkOutput("div0 flag held", 64'(bus.div_zero), 64'd1);
        applyStimulus(32'd10, 32'd3);
        checkOutput("div0 cleared", 64'(bus.div_zero), 64'd0);
        waitDone("10/3", 32'd10, 32'd3, 1'b0);

        $display("[TB] busy protection");
        applyStimulus(32'd50, 32'd5);
        waitDone("busy poke", 32'd50, 32'd5, 1'b1);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) pulses++;
        end
        checkOutput("busy poke single done", 64'(pulses), 64'd0);
        checkOutput("busy poke idle", 64'(bus.busy), 64'd0);

        $display("[TB] random operands");
        for (int i = 0; i < 1000; i++) begin
            a = $urandom >> $urandom_range(0, 8);
            b = $urandom >> $urandom_range(0, 31);
            if (b == 32'd0) b = 32'd1;
            applyStimulus(a, b);
            waitDone("random", a, b, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
